// File: rtl/stack_controller.sv
// stack_controller: push/pop/peek sequencer for the stack half of the data memory.
// Keeps the stack pointer (next free slot, empty-ascending), the occupancy count and the
// full/empty flags, and turns single-cycle command requests into memory write/read cycles.
//
// Optional feature macro: STACK_GUARD_EN
//   defined   : PUSH when full / POP or PEEK when empty is refused with rsp_err=1, 1 cycle after accept
//   undefined : no check, rsp_err stays 0, sp wraps and count saturates
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/ready/op/data     command request (op: 00 PUSH, 01 POP, 10 PEEK, 11 NOP)
//   rsp_valid/data/err          one-cycle completion pulse, read word, guard error
//   mem_address/data/write      data memory address, write data, write strobe
//   mem_stack                   data memory stack_use, high while a command is in flight
//   mem_rdata                   data memory read data (registered read)
//   sp, count, empty, full      stack pointer, occupancy and occupancy flags
module stack_controller #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_write,
   output logic                  mem_stack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      OP_PUSH = 2'b00,
      OP_POP  = 2'b01,
      OP_PEEK = 2'b10,
      OP_NOP  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_WRITE   = 2'b01,
      S_READ    = 2'b10,
      S_CAPTURE = 2'b11
   } state_e;

   state_e                  state, state_n;
   logic                    is_pop, is_pop_n;
   logic [ADDR_WIDTH-1:0]   sp_n, addr_n;
   logic [CNT_WIDTH-1:0]    count_n;
   logic [DATA_WIDTH-1:0]   wdata_n, rsp_data_n;
   logic                    rsp_valid_n, rsp_err_n, mem_write_n, mem_stack_n;
   logic                    guard_hit;
   op_e                     op;

   assign op        = op_e'(cmd_op);
   assign cmd_ready = (state == S_IDLE);
   assign empty     = (count == '0);
   assign full      = (count == DEPTH);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         is_pop      <= 1'b0;
         sp          <= '0;
         count       <= '0;
         mem_address <= '0;
         mem_data    <= '0;
         mem_write   <= 1'b0;
         mem_stack   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
      end else begin
         state       <= state_n;
         is_pop      <= is_pop_n;
         sp          <= sp_n;
         count       <= count_n;
         mem_address <= addr_n;
         mem_data    <= wdata_n;
         mem_write   <= mem_write_n;
         mem_stack   <= mem_stack_n;
         rsp_valid   <= rsp_valid_n;
         rsp_data    <= rsp_data_n;
         rsp_err     <= rsp_err_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      is_pop_n    = is_pop;
      sp_n        = sp;
      count_n     = count;
      addr_n      = mem_address;
      wdata_n     = mem_data;
      rsp_data_n  = rsp_data;
      rsp_valid_n = 1'b0;
      rsp_err_n   = 1'b0;
      mem_write_n = 1'b0;
      guard_hit   = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (cmd_valid) begin
`ifdef STACK_GUARD_EN
               guard_hit = ((op == OP_PUSH) && full) ||
                           (((op == OP_POP) || (op == OP_PEEK)) && empty);
`endif
               if (guard_hit) begin
                  // Refused command: answer immediately, leave memory and pointers alone
                  rsp_valid_n = 1'b1;
                  rsp_data_n  = '0;
                  rsp_err_n   = 1'b1;
               end else begin
                  unique case (op)
                     OP_PUSH: begin
                        addr_n      = sp;
                        wdata_n     = cmd_data;
                        mem_write_n = 1'b1;
                        state_n     = S_WRITE;
                     end
                     OP_POP, OP_PEEK: begin
                        // Top of stack sits one below the next free slot
                        addr_n   = sp - ADDR_WIDTH'(1);
                        is_pop_n = (op == OP_POP);
                        state_n  = S_READ;
                     end
                     default: begin
                        rsp_valid_n = 1'b1;
                        rsp_data_n  = '0;
                     end
                  endcase
               end
            end
         end
         S_WRITE: begin
            sp_n        = sp + ADDR_WIDTH'(1);
            count_n     = full ? count : count + CNT_WIDTH'(1);
            rsp_valid_n = 1'b1;
            rsp_data_n  = '0;
            state_n     = S_IDLE;
         end
         S_READ: begin
            // Address held one full cycle for the memory's registered read
            state_n = S_CAPTURE;
         end
         S_CAPTURE: begin
            rsp_data_n  = mem_rdata;
            rsp_valid_n = 1'b1;
            if (is_pop) begin
               sp_n    = sp - ADDR_WIDTH'(1);
               count_n = empty ? count : count - CNT_WIDTH'(1);
            end
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      mem_stack_n = (state_n != S_IDLE);
   end

endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: self-checking bench for stack_controller (4-deep stack).
// A behavioural stack model (array + pointer arithmetic) predicts every response;
// a small registered-read memory stands in for the data memory.
module tb_stack_controller;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;
`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b11;
   logic [DW-1:0] cmd_data = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data;
   logic          mem_write;
   logic          mem_stack;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] sp;
   logic [AW:0]   count;
   logic          empty;
   logic          full;

   int checks = 0;
   int errors = 0;

   stack_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_address(mem_address), .mem_data(mem_data), .mem_write(mem_write),
      .mem_stack(mem_stack), .mem_rdata(mem_rdata),
      .sp(sp), .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   // Data memory stand-in: synchronous write, registered read
   logic [DW-1:0] mem [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      mem_rdata = '0;
   end
   always @(posedge clk) begin
      if (mem_write) mem[mem_address] <= mem_data;
      mem_rdata <= mem[mem_address];
   end

   // Reference model: stack contents, pointer and occupancy
   logic [DW-1:0] ref_mem [DEPTH];
   int            ref_sp;
   int            ref_count;
   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_sp = 0;
      ref_count = 0;
   end

   task automatic ref_apply(input logic [1:0] op, input logic [DW-1:0] d,
                            output int lat, output logic [DW-1:0] data, output logic err);
      data = '0;
      err  = 1'b0;
      lat  = 1;
      case (op)
         2'b00: if (GUARD && ref_count == DEPTH) err = 1'b1;
                else begin
                   ref_mem[ref_sp] = d;
                   ref_sp = (ref_sp + 1) % DEPTH;
                   if (ref_count < DEPTH) ref_count++;
                   lat = 2;
                end
         2'b01: if (GUARD && ref_count == 0) err = 1'b1;
                else begin
                   ref_sp = (ref_sp + DEPTH - 1) % DEPTH;
                   data = ref_mem[ref_sp];
                   if (ref_count > 0) ref_count--;
                   lat = 3;
                end
         2'b10: if (GUARD && ref_count == 0) err = 1'b1;
                else begin
                   data = ref_mem[(ref_sp + DEPTH - 1) % DEPTH];
                   lat = 3;
                end
         default: lat = 1;
      endcase
   endtask

   // Drives one command from a negedge and observes it until rsp_valid (bounded).
   task automatic issue(input logic [1:0] op, input logic [DW-1:0] d,
                        output int lat, output logic [DW-1:0] rd, output logic re,
                        output int nwr, output logic [AW-1:0] waddr, output bit stk,
                        output bit rdy_busy, output logic [AW-1:0] raddr);
      int w;
      w = 0; lat = 99; rd = '0; re = 1'b0; nwr = 0; waddr = '0; stk = 1'b0;
      rdy_busy = 1'b0; raddr = '0;
      while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_write) begin nwr++; waddr = mem_address; end
         if (mem_stack) stk = 1'b1;
         if (c == 1) raddr = mem_address;
         if (rsp_valid) begin lat = c; rd = rsp_data; re = rsp_err; break; end
         if (cmd_ready) rdy_busy = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ref_sp = 0; ref_count = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({rsp_valid, rsp_err, mem_write, mem_stack, full, empty, cmd_ready} !== 7'b0000011) begin errors++; $display("FAIL reset_flags: got %b expected 0000011", {rsp_valid, rsp_err, mem_write, mem_stack, full, empty, cmd_ready}); end
      checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
      checks++; if ({mem_address, mem_data} !== '0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_address, mem_data); end
      checks++; if ({sp, count} !== '0) begin errors++; $display("FAIL reset_sp_count: got %0d/%0d expected 0/0", sp, count); end
      rst = 1'b0;
      ref_sp = 0; ref_count = 0;
   endtask

   task automatic test_push();
      int lat, el, nwr; logic [DW-1:0] rd, ed; logic re, ee; logic [AW-1:0] wa, ra; bit stk, rb;
      do_reset();
      ref_apply(2'b00, 32'hA5A5_0001, el, ed, ee);
      issue(2'b00, 32'hA5A5_0001, lat, rd, re, nwr, wa, stk, rb, ra);
      checks++; if (lat !== 2) begin errors++; $display("FAIL push_latency: got %0d expected 2", lat); end
      checks++; if (nwr !== 1 || wa !== 2'd0) begin errors++; $display("FAIL push_write: got %0d writes at %0d expected 1 at 0", nwr, wa); end
      checks++; if (stk !== 1'b1) begin errors++; $display("FAIL push_stack_use: got %b expected 1", stk); end
      checks++; if (mem[0] !== 32'hA5A5_0001) begin errors++; $display("FAIL push_mem: got %h expected a5a50001", mem[0]); end
      checks++; if (sp !== 2'd1 || count !== 3'd1 || rd !== ed) begin errors++; $display("FAIL push_state: got sp=%0d count=%0d data=%h expected 1/1/%h", sp, count, rd, ed); end
   endtask

   task automatic test_lifo();
      int lat, el, nwr; logic [DW-1:0] rd, ed; logic re, ee; logic [AW-1:0] wa, ra; bit stk, rb;
      logic [DW-1:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ref_apply(2'b00, vals[i], el, ed, ee);
         issue(2'b00, vals[i], lat, rd, re, nwr, wa, stk, rb, ra);
      end
      for (int i = 2; i >= 0; i--) begin
         ref_apply(2'b01, '0, el, ed, ee);
         issue(2'b01, '0, lat, rd, re, nwr, wa, stk, rb, ra);
         checks++; if (rd !== vals[i] || rd !== ed) begin errors++; $display("FAIL lifo_pop_data: got %h expected %h", rd, vals[i]); end
         checks++; if (lat !== 3) begin errors++; $display("FAIL lifo_pop_latency: got %0d expected 3", lat); end
         checks++; if (ra !== AW'(i)) begin errors++; $display("FAIL lifo_pop_addr: got %0d expected %0d", ra, i); end
      end
      checks++; if (empty !== 1'b1 || sp !== 2'd0 || count !== 3'd0) begin errors++; $display("FAIL lifo_end: got empty=%b sp=%0d count=%0d expected 1/0/0", empty, sp, count); end
   endtask

   task automatic test_peek();
      int lat, el, nwr; logic [DW-1:0] rd, ed; logic re, ee; logic [AW-1:0] wa, ra; bit stk, rb;
      do_reset();
      ref_apply(2'b00, 32'h77, el, ed, ee);
      issue(2'b00, 32'h77, lat, rd, re, nwr, wa, stk, rb, ra);
      for (int i = 0; i < 2; i++) begin
         ref_apply(2'b10, '0, el, ed, ee);
         issue(2'b10, '0, lat, rd, re, nwr, wa, stk, rb, ra);
         checks++; if (rd !== 32'h77 || lat !== 3) begin errors++; $display("FAIL peek_data: got %h at +%0d expected 77 at +3", rd, lat); end
         checks++; if (sp !== 2'd1 || count !== 3'd1) begin errors++; $display("FAIL peek_state: got sp=%0d count=%0d expected 1/1", sp, count); end
      end
   endtask

   task automatic test_boundary();
      int lat, el, nwr; logic [DW-1:0] rd, ed; logic re, ee; logic [AW-1:0] wa, ra; bit stk, rb;
      do_reset();
      ref_apply(2'b01, '0, el, ed, ee);
      issue(2'b01, '0, lat, rd, re, nwr, wa, stk, rb, ra);
`ifdef STACK_GUARD_EN
      checks++; if (re !== 1'b1 || lat !== 1 || stk !== 1'b0) begin errors++; $display("FAIL underflow_guard: got err=%b lat=%0d stack=%b expected 1/1/0", re, lat, stk); end
      checks++; if (sp !== 2'd0 || count !== 3'd0) begin errors++; $display("FAIL underflow_state: got sp=%0d count=%0d expected 0/0", sp, count); end
`else
      checks++; if (re !== 1'b0 || lat !== 3 || ra !== 2'd3 || mem_address !== 2'd3) begin errors++; $display("FAIL underflow_wrap: got err=%b lat=%0d addr=%0d expected 0/3/3", re, lat, ra); end
      checks++; if (sp !== 2'd3 || count !== 3'd0) begin errors++; $display("FAIL underflow_state: got sp=%0d count=%0d expected 3/0", sp, count); end
`endif
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ref_apply(2'b00, 32'h100 + i, el, ed, ee);
         issue(2'b00, 32'h100 + i, lat, rd, re, nwr, wa, stk, rb, ra);
      end
      checks++; if (full !== 1'b1 || count !== 3'd4 || sp !== 2'd0) begin errors++; $display("FAIL fill: got full=%b count=%0d sp=%0d expected 1/4/0", full, count, sp); end
      ref_apply(2'b00, 32'hDEAD, el, ed, ee);
      issue(2'b00, 32'hDEAD, lat, rd, re, nwr, wa, stk, rb, ra);
`ifdef STACK_GUARD_EN
      checks++; if (re !== 1'b1 || lat !== 1 || nwr !== 0 || full !== 1'b1) begin errors++; $display("FAIL overflow_guard: got err=%b lat=%0d writes=%0d full=%b expected 1/1/0/1", re, lat, nwr, full); end
`else
      checks++; if (re !== 1'b0 || nwr !== 1 || wa !== 2'd0 || sp !== 2'd1 || count !== 3'd4) begin errors++; $display("FAIL overflow_wrap: got err=%b writes=%0d at %0d sp=%0d count=%0d expected 0/1/0/1/4", re, nwr, wa, sp, count); end
`endif
      checks++; if (sp !== AW'(ref_sp) || count !== 3'(ref_count)) begin errors++; $display("FAIL overflow_model: got sp=%0d count=%0d expected %0d/%0d", sp, count, ref_sp, ref_count); end
   endtask

   task automatic test_random();
      int lat, el, nwr; logic [DW-1:0] rd, ed, d; logic re, ee; logic [AW-1:0] wa, ra; bit stk, rb;
      logic [1:0] op;
      do_reset();
      for (int n = 0; n < 80; n++) begin
         op = 2'($urandom_range(0, 3));
         d  = $urandom;
         ref_apply(op, d, el, ed, ee);
         issue(op, d, lat, rd, re, nwr, wa, stk, rb, ra);
         checks++; if (lat !== el || rd !== ed || re !== ee) begin errors++; $display("FAIL rand_rsp[%0d] op=%0d: got lat=%0d data=%h err=%b expected %0d/%h/%b", n, op, lat, rd, re, el, ed, ee); end
         checks++; if (sp !== AW'(ref_sp) || count !== 3'(ref_count) || empty !== (ref_count == 0) || full !== (ref_count == DEPTH)) begin errors++; $display("FAIL rand_state[%0d]: got sp=%0d count=%0d e=%b f=%b expected %0d/%0d", n, sp, count, empty, full, ref_sp, ref_count); end
         checks++; if (nwr !== ((op == 2'b00 && !ee) ? 1 : 0) || stk !== (el > 1)) begin errors++; $display("FAIL rand_mem[%0d]: got writes=%0d stack=%b expected %0d/%b", n, nwr, stk, (op == 2'b00 && !ee) ? 1 : 0, el > 1); end
         checks++; if (rb !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rand_ready[%0d]: got busy_ready=%b rsp_ready=%b expected 0/1", n, rb, cmd_ready); end
      end
   endtask

   task automatic test_reset_mid();
      int lat, el, nwr, seen; logic [DW-1:0] rd, ed; logic re, ee; logic [AW-1:0] wa, ra; bit stk, rb;
      do_reset();
      ref_apply(2'b00, 32'h5, el, ed, ee);
      issue(2'b00, 32'h5, lat, rd, re, nwr, wa, stk, rb, ra);
      cmd_valid = 1'b1; cmd_op = 2'b01;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if ({rsp_valid, rsp_err, mem_write, mem_stack, cmd_ready} !== 5'b00001) begin errors++; $display("FAIL midreset_flags: got %b expected 00001", {rsp_valid, rsp_err, mem_write, mem_stack, cmd_ready}); end
      checks++; if ({sp, count, mem_address, mem_data, rsp_data} !== '0) begin errors++; $display("FAIL midreset_regs: got sp=%0d count=%0d addr=%0d", sp, count, mem_address); end
      @(negedge clk);
      rst = 1'b0;
      ref_sp = 0; ref_count = 0;
      seen = 0;
      repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_rsp: got %0d pulses expected 0", seen); end
   endtask

   initial begin
      test_reset();
      test_push();
      test_lifo();
      test_peek();
      test_boundary();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
